// File: rtl/uart_tx_framer_if.sv
// Byte-source handshake between a user-side producer and the UART TX framer.
// A transfer happens on a clock edge where tx_valid and tx_ready are both high.
interface uart_tx_framer_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start, LSB-first data, optional parity and stop bits.
// All bit timing comes from the external baud_pulse strobe; tx is registered.
module uart_tx_framer #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            baud_pulse,
  uart_tx_framer_if.slave src,
  output logic            tx,
  output logic            tx_busy
);

  typedef enum logic [2:0] {StIdle, StWait, StStart, StData, StParity, StStop} state_e;

  localparam logic [3:0] LastData = 4'(DATA_BITS - 1);
  localparam logic [3:0] LastStop = 4'(STOP_BITS - 1);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 accept;

  assign accept = (state_q == StIdle) && src.tx_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
  end

  // Accept wins over a coincident baud_pulse: IDLE never looks at the pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StWait;
      StWait:   if (baud_pulse) state_d = StStart;
      StStart:  if (baud_pulse) state_d = StData;
      StData: begin
        if (baud_pulse && cnt_q == LastData) begin
          state_d = (PARITY_EN != 0) ? StParity : StStop;
        end
      end
      StParity: if (baud_pulse) state_d = StStop;
      StStop:   if (baud_pulse && cnt_q == LastStop) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    tx_d    = tx_q;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (accept) begin
          shift_d = src.tx_data;
          par_d   = (^src.tx_data) ^ 1'(PARITY_ODD);
          cnt_d   = '0;
        end
      end
      StWait: if (baud_pulse) tx_d = 1'b0;
      StStart: begin
        if (baud_pulse) begin
          tx_d  = shift_q[0];
          cnt_d = '0;
        end
      end
      StData: begin
        if (baud_pulse) begin
          if (cnt_q == LastData) begin
            tx_d  = (PARITY_EN != 0) ? par_q : 1'b1;
            cnt_d = '0;
          end else begin
            // shift_q[1] is the bit that lands in position 0 after this shift
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
            cnt_d   = cnt_q + 4'd1;
          end
        end
      end
      StParity: begin
        if (baud_pulse) begin
          tx_d  = 1'b1;
          cnt_d = '0;
        end
      end
      StStop: begin
        if (baud_pulse) begin
          tx_d  = 1'b1;
          cnt_d = (cnt_q == LastStop) ? 4'd0 : cnt_q + 4'd1;
        end
      end
      default: tx_d = 1'b1;
    endcase
  end

  assign tx           = tx_q;
  assign src.tx_ready = (state_q == StIdle);
  assign tx_busy      = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: four configurations (8N1, 8E1, 8O1, 7N2) run side by side,
// each checked every cycle against a frame-list model of the serial line.
module tb_uart_tx_framer;

  localparam int Div = 16;

  logic       clk;
  logic       rst;
  logic       baud_pulse;
  logic [7:0] bcnt = 8'd0;
  logic [7:0] dat [4];
  logic       vld [4];
  logic       txw [4];
  logic       rdy [4];
  logic       bsy [4];

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference model: a frame is a list of line levels, one per bit period.
  bit fr    [4][16];
  int flen  [4];
  bit mbusy [4];
  int mpos  [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) bcnt <= (bcnt == 8'(Div - 1)) ? 8'd0 : bcnt + 8'd1;
  assign baud_pulse = (bcnt == 8'(Div - 1));

  uart_tx_framer_if #(.DATA_BITS(8)) if0 ();
  uart_tx_framer_if #(.DATA_BITS(8)) if1 ();
  uart_tx_framer_if #(.DATA_BITS(8)) if2 ();
  uart_tx_framer_if #(.DATA_BITS(7)) if3 ();

  assign if0.tx_data  = dat[0];
  assign if0.tx_valid = vld[0];
  assign rdy[0]       = if0.tx_ready;
  assign if1.tx_data  = dat[1];
  assign if1.tx_valid = vld[1];
  assign rdy[1]       = if1.tx_ready;
  assign if2.tx_data  = dat[2];
  assign if2.tx_valid = vld[2];
  assign rdy[2]       = if2.tx_ready;
  assign if3.tx_data  = dat[3][6:0];
  assign if3.tx_valid = vld[3];
  assign rdy[3]       = if3.tx_ready;

  uart_tx_framer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .src(if0), .tx(txw[0]), .tx_busy(bsy[0])
  );
  uart_tx_framer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .src(if1), .tx(txw[1]), .tx_busy(bsy[1])
  );
  uart_tx_framer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .src(if2), .tx(txw[2]), .tx_busy(bsy[2])
  );
  uart_tx_framer #(.DATA_BITS(7), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
    .clk(clk), .rst(rst), .baud_pulse(baud_pulse), .src(if3), .tx(txw[3]), .tx_busy(bsy[3])
  );

  function automatic int cfg_db(int i); return (i == 3) ? 7 : 8; endfunction
  function automatic int cfg_pe(int i); return (i == 1 || i == 2) ? 1 : 0; endfunction
  function automatic int cfg_po(int i); return (i == 2) ? 1 : 0; endfunction
  function automatic int cfg_sb(int i); return (i == 3) ? 2 : 1; endfunction

  task automatic load_frame(int i, logic [7:0] d);
    int n = 1;
    int ones = 0;
    fr[i][0] = 1'b0;
    for (int k = 0; k < cfg_db(i); k++) begin
      fr[i][n] = d[k];
      ones += int'(d[k]);
      n++;
    end
    if (cfg_pe(i) != 0) begin
      fr[i][n] = ((ones % 2) != cfg_po(i));
      n++;
    end
    for (int k = 0; k < cfg_sb(i); k++) begin
      fr[i][n] = 1'b1;
      n++;
    end
    flen[i] = n;
  endtask

  // Compare all DUTs at the falling edge, then advance the model with the inputs that
  // the coming rising edge will sample; returns just after that edge.
  task automatic tick();
    logic [2:0] exp_v;
    logic [2:0] got_v;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      if (mbusy[i]) exp_v = {(mpos[i] < 0) ? 1'b1 : logic'(fr[i][mpos[i]]), 1'b0, 1'b1};
      else          exp_v = 3'b110;
      got_v = {txw[i], rdy[i], bsy[i]};
      checks++;
      assert (got_v === exp_v) else begin
        errors++;
        $error("FAIL line dut%0d t=%0t {tx,ready,busy} got %b want %b", i, $time, got_v, exp_v);
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        mbusy[i] = 1'b0;
      end else if (!mbusy[i]) begin
        if (vld[i]) begin
          load_frame(i, dat[i]);
          mbusy[i] = 1'b1;
          mpos[i]  = -1;
        end
      end else if (baud_pulse) begin
        mpos[i]++;
        if (mpos[i] == flen[i]) mbusy[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(int i);
    int n = 0;
    while (mbusy[i] && n < 400) begin
      tick();
      n++;
    end
    checks++;
    assert (mbusy[i] === 1'b0) else begin
      errors++;
      $error("FAIL timeout dut%0d busy after %0d cycles, want idle", i, n);
    end
  endtask

  task automatic send(int i, logic [7:0] d);
    dat[i] = d;
    vld[i] = 1'b1;
    tick();
    vld[i] = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vld[i]   = 1'b0;
      dat[i]   = 8'h00;
      mbusy[i] = 1'b0;
      mpos[i]  = 0;
      flen[i]  = 0;
    end
    @(posedge clk);
    #1;
    // Reset held, then idle with pulses running: line must stay at mark.
    repeat (3) tick();
    rst = 1'b0;
    repeat (40) tick();

    // 8N1 0x55, then parity frames of 0x07 (even and odd).
    send(0, 8'h55);
    wait_idle(0);
    dat[1] = 8'h07;
    dat[2] = 8'h07;
    vld[1] = 1'b1;
    vld[2] = 1'b1;
    tick();
    vld[1] = 1'b0;
    vld[2] = 1'b0;
    wait_idle(1);
    wait_idle(2);

    // tx_valid held: 0xA3 then 0x3C; data wiggles mid-frame must not leak in.
    dat[0] = 8'hA3;
    vld[0] = 1'b1;
    tick();
    repeat (50) tick();
    dat[0] = 8'hFF;
    repeat (50) tick();
    dat[0] = 8'h3C;
    n = 0;
    while (mbusy[0] && n < 400) begin
      tick();
      n++;
    end
    tick();
    vld[0] = 1'b0;
    dat[0] = 8'hFF;
    wait_idle(0);

    // Reset during data bit 4 of 0x00, then a clean frame.
    send(0, 8'h00);
    n = 0;
    while (mbusy[0] && mpos[0] < 5 && n < 400) begin
      tick();
      n++;
    end
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (5) tick();
    send(0, 8'h5A);
    wait_idle(0);

    // 7N2 0x7F, then an accept on the same edge as a baud pulse.
    send(3, 8'h7F);
    wait_idle(3);
    n = 0;
    while (bcnt != 8'(Div - 1) && n < 2 * Div) begin
      tick();
      n++;
    end
    send(3, 8'h15);
    wait_idle(3);

    // Random traffic on all four framers, with rare resets.
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!mbusy[i]) vld[i] = ($urandom_range(0, 3) == 0);
        else           vld[i] = 1'($urandom_range(0, 1));
        dat[i] = 8'($urandom);
      end
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) vld[i] = 1'b0;
    for (int i = 0; i < 4; i++) wait_idle(i);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
